// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and opcode-class constants for the CPU memory port
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_t;

  typedef enum logic {
    DEST_IR,
    DEST_MDR
  } dest_t;

  localparam logic [1:0] OPC_LOAD  = 2'b00;
  localparam logic [1:0] OPC_STORE = 2'b01;

endpackage

// File: rtl/mem_port_ctrl.sv
// rtl/mem_port_ctrl.sv - registered single-port RAM controller for fetch and load/store phases
// Optional store write-protection above GUARD_BASE is enabled by defining MEM_GUARD_EN.
module mem_port_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 12,
  parameter int                RD_LAT     = 1,
  parameter int                PHASE_W    = 5,
  parameter int                FETCH_BIT  = 0,
  parameter int                MEM_BIT    = 2,
  parameter logic [ADDR_W-1:0] GUARD_BASE = 12'hF00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PHASE_W-1:0] phase,
  input  logic [DATA_W-1:0] instr,
  input  logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] ra,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdr,
  output logic              stall,
  output logic              fault
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  state_t              state, state_d;
  dest_t               dest, dest_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic [PHASE_W-1:0]  phase_q;
  logic [ADDR_W-1:0]   address_d;
  logic                wren_d;
  logic [DATA_W-1:0]   data_d, ir_d, mdr_d;
  logic                fault_q, fault_d;

  logic                start, is_fetch, is_load, is_store;
  logic [1:0]          opc;
  logic [ADDR_W-1:0]   ea;

  always_comb begin
    opc      = instr[DATA_W-1 -: 2];
    ea       = result[ADDR_W-1:0];
    start    = (phase != phase_q);
    // Fetch wins if a malformed phase vector has both bits set.
    is_fetch = start & phase[FETCH_BIT];
    is_load  = start & ~phase[FETCH_BIT] & phase[MEM_BIT] & (opc == OPC_LOAD);
    is_store = start & ~phase[FETCH_BIT] & phase[MEM_BIT] & (opc == OPC_STORE);
    stall    = (state != IDLE) | is_fetch | is_load | is_store;
  end

  always_comb begin
    state_d   = state;
    dest_d    = dest;
    cnt_d     = cnt;
    address_d = address;
    wren_d    = wren;
    data_d    = data;
    ir_d      = ir;
    mdr_d     = mdr;
    fault_d   = fault_q;
    case (state)
      IDLE: begin
        address_d = pc;
        if (is_fetch) begin
          wren_d  = 1'b0;
          dest_d  = DEST_IR;
          cnt_d   = CNT_W'(RD_LAT);
          state_d = RD;
        end else if (is_load) begin
          address_d = ea;
          dest_d    = DEST_MDR;
          cnt_d     = CNT_W'(RD_LAT);
          state_d   = RD;
        end else if (is_store) begin
          address_d = ea;
          state_d   = WR;
`ifdef MEM_GUARD_EN
          if (ea >= GUARD_BASE) begin
            fault_d = 1'b1;
          end else begin
            wren_d = 1'b1;
            data_d = ra;
          end
`else
          wren_d = 1'b1;
          data_d = ra;
`endif
        end
      end
      RD: begin
        if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          if (dest == DEST_IR) ir_d = mem_q;
          else                 mdr_d = mem_q;
          address_d = pc;
          state_d   = IDLE;
        end
      end
      WR: begin
        wren_d    = 1'b0;
        data_d    = '0;
        address_d = pc;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      dest    <= DEST_IR;
      cnt     <= '0;
      phase_q <= '0;
      address <= '0;
      wren    <= 1'b0;
      data    <= '0;
      ir      <= '0;
      mdr     <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_d;
      dest    <= dest_d;
      cnt     <= cnt_d;
      phase_q <= phase;
      address <= address_d;
      wren    <= wren_d;
      data    <= data_d;
      ir      <= ir_d;
      mdr     <= mdr_d;
      fault_q <= fault_d;
    end
  end

`ifdef MEM_GUARD_EN
  assign fault = fault_q;
  logic unused_ok;
  assign unused_ok = ^{instr[DATA_W-3:0], result[DATA_W-1:ADDR_W]};
`else
  assign fault = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{instr[DATA_W-3:0], result[DATA_W-1:ADDR_W], fault_q, GUARD_BASE};
`endif

endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb/tb_mem_port_ctrl.sv - randomized transaction-level self-checking bench for mem_port_ctrl
module tb_mem_port_ctrl;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  phase;
  logic [15:0] instr;
  logic [11:0] pc;
  logic [15:0] result;
  logic [15:0] ra;
  logic [15:0] mem_q;
  logic [11:0] address;
  logic        wren;
  logic [15:0] data;
  logic [15:0] ir;
  logic [15:0] mdr;
  logic        stall;
  logic        fault;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] ram     [0:4095];
  logic [15:0] ref_mem [0:4095];
  logic [15:0] rdp     [0:LAT-1];
  logic [15:0] m_ir, m_mdr;
  logic        m_fault;
  logic [4:0]  cur_phase;

  always #5 clk = ~clk;

  mem_port_ctrl #(.RD_LAT(LAT)) u_dut (
    .clk     (clk),
    .reset   (reset),
    .phase   (phase),
    .instr   (instr),
    .pc      (pc),
    .result  (result),
    .ra      (ra),
    .mem_q   (mem_q),
    .address (address),
    .wren    (wren),
    .data    (data),
    .ir      (ir),
    .mdr     (mdr),
    .stall   (stall),
    .fault   (fault)
  );

  function automatic logic [15:0] init_val(input logic [11:0] a);
    if (a == 12'h010) return 16'hA5C3;
    if (a == 12'h123) return 16'hBEEF;
    return {a[3:0], a} ^ 16'h3C96;
  endfunction

  // Synchronous RAM with LAT cycles of read latency.
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_val(12'(i));
    for (int i = 0; i < LAT; i++) rdp[i] = '0;
    forever begin
      @(posedge clk);
      rdp[0] <= ram[address];
      for (int i = 1; i < LAT; i++) rdp[i] <= rdp[i-1];
      if (wren) ram[address] = data;
    end
  end
  assign mem_q = rdp[LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return 12'hF00 + 12'($urandom_range(0, 15));
      1:       return 12'h010;
      default: return 12'h040 + 12'($urandom_range(0, 7));
    endcase
  endfunction

  task automatic run_txn(input logic [4:0] ph, input logic [15:0] ins, input logic [11:0] p,
                         input logic [15:0] res, input logic [15:0] d);
    logic [11:0] ea;
    logic [1:0]  opc;
    bit          is_rd, is_st, to_ir, guarded, done;
    int          exp_len, n, nw;
    ea      = res[11:0];
    opc     = ins[15:14];
    to_ir   = ph[0];
    is_rd   = ph[0] || (ph[2] && opc == 2'b00);
    is_st   = !ph[0] && ph[2] && opc == 2'b01;
    exp_len = is_rd ? LAT + 2 : (is_st ? 2 : 0);
    guarded = 1'b0;
`ifdef MEM_GUARD_EN
    guarded = is_st && (ea >= 12'hF00);
`endif
    if (is_rd && to_ir) m_ir = ref_mem[p];
    else if (is_rd)     m_mdr = ref_mem[ea];
    if (is_st && !guarded) ref_mem[ea] = d;
    if (guarded) m_fault = 1'b1;

    @(negedge clk);
    pc = p; instr = ins; result = res; ra = d; phase = ph; cur_phase = ph;
    #1;
    n = 0; nw = 0; done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (c == 1 && exp_len != 0) check("acc_addr", 32'(address), 32'((is_rd && to_ir) ? p : ea));
      if (wren) begin
        nw++;
        check("wr_addr", 32'(address), 32'(ea));
        check("wr_data", 32'(data), 32'(d));
      end
      if (!stall) begin
        done = 1'b1;
        break;
      end
      n++;
      @(negedge clk); #1;
    end
    check("stall_done", 32'(done), 32'd1);
    check("stall_len", 32'(n), 32'(exp_len));
    check("wren_cycles", 32'(nw), 32'((is_st && !guarded) ? 1 : 0));
    @(negedge clk); #1;
    check("idle_addr", 32'(address), 32'(p));
    check("idle_wren", 32'(wren), 32'd0);
    check("idle_data", 32'(data), 32'd0);
    check("ir", 32'(ir), 32'(m_ir));
    check("mdr", 32'(mdr), 32'(m_mdr));
    check("fault", 32'(fault), 32'(m_fault));
  endtask

  initial begin
    logic [4:0] ph;
    logic [15:0] ins;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    m_ir = '0; m_mdr = '0; m_fault = 1'b0;
    reset = 1'b1; phase = '0; cur_phase = '0;
    instr = '0; pc = '0; result = '0; ra = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_addr", 32'(address), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ir", 32'(ir), 32'd0);
    check("rst_mdr", 32'(mdr), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);

    // Load aborted by reset; a phase change mid-read must not start a new access.
    @(negedge clk);
    reset = 1'b0; pc = 12'h020;
    @(negedge clk);
    phase = 5'b00100; instr = 16'h0000; result = 16'h0123; #1;
    check("abort_start_stall", 32'(stall), 32'd1);
    @(negedge clk);
    phase = 5'b00001; #1;
    check("abort_rd_stall", 32'(stall), 32'd1);
    @(negedge clk); #1;
    check("abort_ignored_addr", 32'(address), 32'h123);
    reset = 1'b1; phase = '0;
    @(negedge clk); #1;
    check("abort_addr", 32'(address), 32'd0);
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_mdr", 32'(mdr), 32'd0);
    check("abort_ir", 32'(ir), 32'd0);
    check("abort_stall", 32'(stall), 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check("abort_track_pc", 32'(address), 32'h020);
    cur_phase = '0;

    run_txn(5'b00001, 16'h8000, 12'h010, 16'h0000, 16'h0000);
    run_txn(5'b00100, 16'h0000, 12'h010, 16'h0123, 16'h0000);
    run_txn(5'b00010, 16'h0000, 12'h011, 16'h0000, 16'h0000);
    run_txn(5'b00100, 16'h4000, 12'h012, 16'h0042, 16'h1234);
    run_txn(5'b01000, 16'h0000, 12'h013, 16'h0000, 16'h0000);
    run_txn(5'b00100, 16'hC000, 12'h014, 16'h0042, 16'h0000);
    run_txn(5'b00010, 16'h0000, 12'h015, 16'h0000, 16'h0000);
    run_txn(5'b00100, 16'h4000, 12'h016, 16'h0F10, 16'h5555);
    run_txn(5'b00001, 16'h0000, 12'h017, 16'h0000, 16'h0000);
    run_txn(5'b00100, 16'h0000, 12'h018, 16'h0042, 16'h0000);
    run_txn(5'b00001, 16'h0000, 12'h019, 16'h0000, 16'h0000);
    run_txn(5'b00100, 16'h0000, 12'h01A, 16'h0F10, 16'h0000);

    for (int t = 0; t < 200; t++) begin
      do ph = 5'b00001 << $urandom_range(0, 4); while (ph == cur_phase);
      ins = 16'($urandom);
      run_txn(ph, ins, pick_addr(), {4'($urandom), pick_addr()}, 16'($urandom));
    end

    @(negedge clk);
    reset = 1'b1; phase = '0;
    @(negedge clk); #1;
    check("final_rst_fault", 32'(fault), 32'd0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
